buffer_pe_vc_fifo: RTL and testbench

- Parametrised successor to the single-entry ring-PE input buffer: one FIFO of DEPTH entries per virtual channel (even, odd) instead of one register per channel.
- Sits between the ring input link (cwsi/cwri/cwdi) and the PE-side cw/ccw output arbiters.
- Global polarity selects which VC accepts writes and which VC drains.
- Adds occupancy reporting and a drop strobe for packets whose VC bit does not match the accepting VC.

---
 rtl/buffer_pe_vc_fifo.sv | 110 +++++++++++
 tb/tb_buffer_pe_vc_fifo.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/buffer_pe_vc_fifo.sv
// Ring-PE input buffer with one DEPTH-entry FIFO per virtual channel (even/odd).
// Polarity picks which VC accepts from the ring link; the other VC drains to the cw/ccw arbiters.
module buffer_pe_vc_fifo #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 4,
  parameter int VC_BIT  = DATA_W - 1,
  parameter int DIR_BIT = DATA_W - 2,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  input  logic              cwsi,
  input  logic [DATA_W-1:0] cwdi,
  output logic              cwri,
  input  logic              cwro_cw,
  input  logic              cwro_ccw,
  input  logic              write_en_cw,
  input  logic              write_en_ccw,
  output logic              cwso_cw,
  output logic              cwso_ccw,
  output logic [DATA_W-1:0] cwdo_even,
  output logic [DATA_W-1:0] cwdo_odd,
  output logic [CNT_W-1:0]  cnt_even,
  output logic [CNT_W-1:0]  cnt_odd,
  output logic              drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic VC_EVEN = 1'b0;
  localparam logic VC_ODD  = 1'b1;

  // Storage and bookkeeping indexed by VC: [0] = even, [1] = odd.
  logic [DATA_W-1:0] r_mem    [2][DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr [2];
  logic [PTR_W-1:0]  r_rd_ptr [2];
  logic [CNT_W-1:0]  r_cnt    [2];
  logic              r_drop;

  logic              w_vc_a;
  logic              w_vc_d;
  logic              w_full_a;
  logic              w_tag_ok;
  logic              w_enq;
  logic              w_drop_set;
  logic [DATA_W-1:0] w_head_d;
  logic              w_dir_d;
  logic              w_nonempty_d;
  logic              w_deq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Role selection follows polarity combinationally.
  assign w_vc_a = polarity ? VC_EVEN : VC_ODD;
  assign w_vc_d = polarity ? VC_ODD  : VC_EVEN;

  assign w_full_a   = (r_cnt[w_vc_a] == CNT_W'(DEPTH));
  assign cwri       = !w_full_a;
  assign w_tag_ok   = (cwdi[VC_BIT] == w_vc_a);
  assign w_enq      = cwsi && cwri && w_tag_ok;
  assign w_drop_set = cwsi && cwri && !w_tag_ok;

  assign w_head_d     = r_mem[w_vc_d][r_rd_ptr[w_vc_d]];
  assign w_dir_d      = w_head_d[DIR_BIT];
  assign w_nonempty_d = (r_cnt[w_vc_d] != '0);

  assign cwso_cw  = w_nonempty_d && cwro_cw  && !w_dir_d;
  assign cwso_ccw = w_nonempty_d && cwro_ccw &&  w_dir_d;
  assign w_deq    = (cwso_cw && write_en_cw) || (cwso_ccw && write_en_ccw);

  // Heads are masked while empty so stale memory never leaks out.
  assign cwdo_even = (r_cnt[VC_EVEN] != '0) ? r_mem[VC_EVEN][r_rd_ptr[VC_EVEN]] : '0;
  assign cwdo_odd  = (r_cnt[VC_ODD]  != '0) ? r_mem[VC_ODD][r_rd_ptr[VC_ODD]]   : '0;
  assign cnt_even  = r_cnt[VC_EVEN];
  assign cnt_odd   = r_cnt[VC_ODD];
  assign drop      = r_drop;

  // NOTE: the packet memory is deliberately not reset; the occupancy mask hides it.
  always_ff @(posedge clk) begin
    if (w_enq && !reset) begin
      r_mem[w_vc_a][r_wr_ptr[w_vc_a]] <= cwdi;
    end
  end

  // Accepting and draining VCs always differ, so each FIFO steps by at most one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr[VC_EVEN] <= '0;
      r_wr_ptr[VC_ODD]  <= '0;
      r_rd_ptr[VC_EVEN] <= '0;
      r_rd_ptr[VC_ODD]  <= '0;
      r_cnt[VC_EVEN]    <= '0;
      r_cnt[VC_ODD]     <= '0;
      r_drop            <= 1'b0;
    end else begin
      r_drop <= w_drop_set;
      if (w_enq) begin
        r_wr_ptr[w_vc_a] <= ptr_inc(r_wr_ptr[w_vc_a]);
        r_cnt[w_vc_a]    <= r_cnt[w_vc_a] + 1'b1;
      end
      if (w_deq) begin
        r_rd_ptr[w_vc_d] <= ptr_inc(r_rd_ptr[w_vc_d]);
        r_cnt[w_vc_d]    <= r_cnt[w_vc_d] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_buffer_pe_vc_fifo.sv
// Self-checking bench for buffer_pe_vc_fifo: directed plan steps, then random traffic,
// all compared against a queue-per-VC reference model.
module tb_buffer_pe_vc_fifo;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset, polarity, cwsi, cwri;
  logic [DATA_W-1:0] cwdi;
  logic              cwro_cw, cwro_ccw, write_en_cw, write_en_ccw;
  logic              cwso_cw, cwso_ccw, drop;
  logic [DATA_W-1:0] cwdo_even, cwdo_odd;
  logic [CNT_W-1:0]  cnt_even, cnt_odd;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one queue per VC plus the pending drop strobe.
  logic [DATA_W-1:0] q_e[$];
  logic [DATA_W-1:0] q_o[$];
  bit                exp_drop;

  always #5 clk = ~clk;

  buffer_pe_vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .cwsi(cwsi), .cwdi(cwdi), .cwri(cwri),
    .cwro_cw(cwro_cw), .cwro_ccw(cwro_ccw),
    .write_en_cw(write_en_cw), .write_en_ccw(write_en_ccw),
    .cwso_cw(cwso_cw), .cwso_ccw(cwso_ccw),
    .cwdo_even(cwdo_even), .cwdo_odd(cwdo_odd),
    .cnt_even(cnt_even), .cnt_odd(cnt_odd), .drop(drop)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input bit odd);
    return odd ? q_o.size() : q_e.size();
  endfunction

  function automatic logic [DATA_W-1:0] qhead(input bit odd);
    if (odd) return (q_o.size() != 0) ? q_o[0] : '0;
    return (q_e.size() != 0) ? q_e[0] : '0;
  endfunction

  task automatic check_outputs();
    bit acc_odd, drn_odd;
    logic [DATA_W-1:0] hd;
    acc_odd = !polarity;
    drn_odd = polarity;
    hd = qhead(drn_odd);
    check("cwri",      {63'b0, cwri},     {63'b0, qsize(acc_odd) < DEPTH});
    check("cwso_cw",   {63'b0, cwso_cw},  {63'b0, (qsize(drn_odd) != 0) && cwro_cw  && !hd[DATA_W-2]});
    check("cwso_ccw",  {63'b0, cwso_ccw}, {63'b0, (qsize(drn_odd) != 0) && cwro_ccw &&  hd[DATA_W-2]});
    check("cwdo_even", cwdo_even, qhead(1'b0));
    check("cwdo_odd",  cwdo_odd,  qhead(1'b1));
    check("cnt_even",  64'(cnt_even), 64'(q_e.size()));
    check("cnt_odd",   64'(cnt_odd),  64'(q_o.size()));
    check("drop",      {63'b0, drop}, {63'b0, exp_drop});
  endtask

  // One clock: drive, check combinational view, then advance model across the edge.
  task automatic cycle(input bit rst, input bit pol, input bit si, input logic [DATA_W-1:0] di,
                       input bit rcw, input bit rccw, input bit wcw, input bit wccw);
    bit acc_odd, drn_odd, enq, drp, deq;
    logic [DATA_W-1:0] hd;
    reset = rst; polarity = pol; cwsi = si; cwdi = di;
    cwro_cw = rcw; cwro_ccw = rccw; write_en_cw = wcw; write_en_ccw = wccw;
    #1;
    check_outputs();
    acc_odd = !pol;
    drn_odd = pol;
    hd  = qhead(drn_odd);
    enq = si && (qsize(acc_odd) < DEPTH) && (di[DATA_W-1] == acc_odd);
    drp = si && (qsize(acc_odd) < DEPTH) && (di[DATA_W-1] != acc_odd);
    deq = (qsize(drn_odd) != 0) &&
          ((rcw && wcw && !hd[DATA_W-2]) || (rccw && wccw && hd[DATA_W-2]));
    @(posedge clk); #1;
    if (rst) begin
      q_e.delete(); q_o.delete(); exp_drop = 1'b0;
    end else begin
      exp_drop = drp;
      if (enq) begin
        if (acc_odd) q_o.push_back(di); else q_e.push_back(di);
      end
      if (deq) begin
        if (drn_odd) void'(q_o.pop_front()); else void'(q_e.pop_front());
      end
    end
  endtask

  task automatic idle(input bit pol);
    cycle(1'b0, pol, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [DATA_W-1:0] pkt;
    bit rst_r;

    // First reset: outputs are unknown until the reset edge, so no checks yet.
    reset = 1'b1; polarity = 1'b0; cwsi = 1'b0; cwdi = '0;
    cwro_cw = 1'b0; cwro_ccw = 1'b0; write_en_cw = 1'b0; write_en_ccw = 1'b0;
    @(posedge clk); #1;
    q_e.delete(); q_o.delete(); exp_drop = 1'b0;
    idle(1'b0);

    // Fill odd with the same cw packet; the 5th send must bounce off a full FIFO.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 64'h8000_0000_0000_0001, 0, 0, 0, 0);
    idle(1'b0);
    check("full_cnt_odd", 64'(cnt_odd), 64'd4);
    check("full_cwri",    {63'b0, cwri}, 64'd0);
    check("full_no_drop", {63'b0, drop}, 64'd0);

    // Fill odd with payloads 1..4 and drain them cw in order.
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b0, 1'b1, 64'h8000_0000_0000_0000 | 64'(i), 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      reset = 1'b0; polarity = 1'b1; cwsi = 1'b0; cwro_cw = 1'b1; write_en_cw = 1'b1;
      #1;
      check("drain_cwso_cw", {63'b0, cwso_cw}, 64'd1);
      check("drain_payload", cwdo_odd, 64'h8000_0000_0000_0000 | 64'(i));
      cycle(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    idle(1'b1);
    check("drained_cwdo_odd", cwdo_odd, 64'd0);

    // ccw-bound head blocks a cw consumer, then leaves through ccw.
    cycle(1'b0, 1'b0, 1'b1, 64'hC000_0000_0000_00AA, 0, 0, 0, 0);
    cycle(1'b0, 1'b0, 1'b1, 64'h8000_0000_0000_000B, 0, 0, 0, 0);
    cycle(1'b0, 1'b0, 1'b1, 64'h8000_0000_0000_000C, 0, 0, 0, 0);
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("ccw_blocked_cnt", 64'(cnt_odd), 64'd3);
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("ccw_deq_cnt", 64'(cnt_odd), 64'd2);

    // Wrong VC tag is dropped with a single-cycle strobe.
    cycle(1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_0005, 0, 0, 0, 0);
    check("drop_pulse", {63'b0, drop}, 64'd1);
    idle(1'b0);
    check("drop_one_cycle", {63'b0, drop}, 64'd0);

    // Simultaneous odd drain and even enqueue.
    cycle(1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_0007, 1'b1, 1'b0, 1'b1, 1'b0);
    check("both_cnt_odd",  64'(cnt_odd),  64'd1);
    check("both_cnt_even", 64'(cnt_even), 64'd1);

    // Build even=3, odd=2, then reset mid-traffic.
    cycle(1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_0008, 0, 0, 0, 0);
    cycle(1'b0, 1'b1, 1'b1, 64'h4000_0000_0000_0009, 0, 0, 0, 0);
    cycle(1'b0, 1'b0, 1'b1, 64'h8000_0000_0000_000D, 0, 0, 0, 0);
    check("pre_rst_even", 64'(cnt_even), 64'd3);
    check("pre_rst_odd",  64'(cnt_odd),  64'd2);
    do_reset();
    idle(1'b1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      pkt = {$urandom, $urandom};
      rst_r = ($urandom_range(0, 199) == 0);
      cycle(rst_r, ($urandom_range(0, 15) < 8), ($urandom_range(0, 3) != 0), pkt,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
